// File: rtl/draw_pkg.sv
// Shared drawing definitions: screen geometry, colours, pixel record and the
// on-screen test used when clipping signed drawer coordinates.
package draw_pkg;

    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] WHITE  = 3'b111;

    typedef logic signed [8:0] coord_x_t;
    typedef logic signed [7:0] coord_y_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_status_t;

    // Signed compare so that negative drawer coordinates count as off-screen.
    function automatic logic in_bounds(coord_x_t px, coord_y_t py, int width, int height);
        return (px >= 9'sd0) && (int'(px) < width) &&
               (py >= 8'sd0) && (int'(py) < height);
    endfunction

endpackage

// File: rtl/pixel_write_queue_if.sv
// Pixel write handshake between a drawing engine (master) and the write queue (slave).
interface pixel_write_queue_if;
    import draw_pkg::*;

    logic       in_valid;
    logic       in_ready;
    coord_x_t   in_x;
    coord_y_t   in_y;
    logic [2:0] in_colour;

    modport master (output in_valid, output in_x, output in_y, output in_colour, input in_ready);
    modport slave  (input in_valid, input in_x, input in_y, input in_colour, output in_ready);

endinterface

// File: rtl/pixel_write_queue_sync_fifo.sv
// Single-clock FIFO with registered occupancy flags and a synchronous clear.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && !empty_r;

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, count and flags; clear wins over any push or pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_FULL);
            empty_r <= (count_next_s == '0);
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) mem_r[wr_ptr_r] <= wdata;
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/pixel_write_queue.sv
// Clips signed pixel writes to the visible screen, queues on-screen pixels and
// replays them to vga_adapter as one registered plot strobe per pixel.
module pixel_write_queue #(
    parameter int SCREEN_WIDTH  = draw_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = draw_pkg::SCREEN_HEIGHT,
    parameter int DEPTH         = 8,
    parameter int DROP_W        = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   sync_clear,
    pixel_write_queue_if.slave     in_bus,
    input  logic                   out_en,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   empty,
    output logic [DROP_W-1:0]      drop_count
);
    import draw_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    pixel_t        wr_pixel_s;
    pixel_t        head_pixel_s;
    logic          in_bounds_s;
    logic          xfer_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    fifo_status_t  status_s;

    logic [7:0]        x_r;
    logic [6:0]        y_r;
    logic [2:0]        colour_r;
    logic              plot_r;
    logic [DROP_W-1:0] drop_count_r;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign in_bus.in_ready = !fifo_full_s;
    assign in_bounds_s     = in_bounds(in_bus.in_x, in_bus.in_y, SCREEN_WIDTH, SCREEN_HEIGHT);
    assign xfer_s          = in_bus.in_valid && !fifo_full_s && !sync_clear;
    assign push_s          = xfer_s && in_bounds_s;
    assign drop_s          = xfer_s && !in_bounds_s;
    assign pop_s           = out_en && (status_s != FIFO_EMPTY) && !sync_clear;

    assign wr_pixel_s = '{x: in_bus.in_x[7:0], y: in_bus.in_y[6:0], colour: in_bus.in_colour};

    // Occupancy class from the registered count.
    always_comb begin
        status_s = FIFO_PARTIAL;
        if (fifo_count_s == '0) begin
            status_s = FIFO_EMPTY;
        end else if (fifo_count_s == CNT_FULL) begin
            status_s = FIFO_FULL;
        end else begin
            status_s = FIFO_PARTIAL;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(pixel_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clear  (sync_clear),
        .push   (push_s),
        .pop    (pop_s),
        .wdata  (wr_pixel_s),
        .rdata  (head_pixel_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .count  (fifo_count_s)
    );

    // Adapter-side registers: load the head on a pop, otherwise hold with plot low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_r      <= 8'd0;
            y_r      <= 7'd0;
            colour_r <= 3'd0;
            plot_r   <= 1'b0;
        end else if (sync_clear) begin
            plot_r   <= 1'b0;
        end else if (pop_s) begin
            x_r      <= head_pixel_s.x;
            y_r      <= head_pixel_s.y;
            colour_r <= head_pixel_s.colour;
            plot_r   <= 1'b1;
        end else begin
            plot_r   <= 1'b0;
        end
    end

    // Saturating clip counter; a flush leaves it untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_count_r <= '0;
        end else if (drop_s && (drop_count_r != DROP_MAX)) begin
            drop_count_r <= drop_count_r + DROP_ONE;
        end
    end

    assign x          = x_r;
    assign y          = y_r;
    assign colour     = colour_r;
    assign plot       = plot_r;
    assign empty      = fifo_empty_s;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Self-checking bench for pixel_write_queue: clip table plus hand-written
// backpressure, streaming, reset and flush sequences, all against a scoreboard.
module tb_pixel_write_queue;
    import draw_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;
    localparam int NVEC   = 9;

    typedef struct {
        logic [8:0] vx;
        logic [7:0] vy;
        logic [2:0] vc;
        logic       keep;
    } clip_vec_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              sync_clear = 1'b0;
    logic              out_en = 1'b0;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [2:0]        colour;
    logic              plot;
    logic              empty;
    logic [DROP_W-1:0] drop_count;

    pixel_write_queue_if pif();

    pixel_write_queue #(
        .SCREEN_WIDTH (160),
        .SCREEN_HEIGHT(120),
        .DEPTH        (DEPTH),
        .DROP_W       (DROP_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sync_clear (sync_clear),
        .in_bus     (pif),
        .out_en     (out_en),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .empty      (empty),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          plot_count = 0;
    int          exp_drops = 0;
    int          snap = 0;
    int          accept_k = -1;
    logic [17:0] sb[$];
    logic [17:0] exp_px;
    logic        rdy;
    logic        bp_done;
    clip_vec_t   vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic record(input logic [8:0] px, input logic [7:0] py, input logic [2:0] pc, input logic keep);
        if (keep) sb.push_back({px[7:0], py[6:0], pc});
        else      exp_drops++;
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send(input logic [8:0] px, input logic [7:0] py, input logic [2:0] pc, input logic keep);
        logic r;
        logic done;
        done = 1'b0;
        pif.in_valid  = 1'b1;
        pif.in_x      = px;
        pif.in_y      = py;
        pif.in_colour = pc;
        for (int t = 0; t < 50 && !done; t++) begin
            r = pif.in_ready;
            @(posedge clk);
            if (r) begin
                record(px, py, pc, keep);
                done = 1'b1;
            end
            @(negedge clk);
        end
        pif.in_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected a transfer");
        end
    endtask

    // Scoreboard: every plot strobe must match the oldest expected pixel.
    always @(negedge clk) begin
        if (resetn && plot) begin
            plot_count++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, expected no plot", x, y, colour);
            end else begin
                exp_px = sb.pop_front();
                if ({x, y, colour} !== exp_px) begin
                    miscompares++;
                    $display("FAIL plot_data: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                             x, y, colour, exp_px[17:10], exp_px[9:3], exp_px[2:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, expected completion");
        $fatal(1);
    end

    initial begin
        pif.in_valid  = 1'b0;
        pif.in_x      = 9'd0;
        pif.in_y      = 8'd0;
        pif.in_colour = 3'd0;

        vecs[0] = '{9'h1FF, 8'd10,  BLUE,   1'b0};
        vecs[1] = '{9'd160, 8'd10,  BLUE,   1'b0};
        vecs[2] = '{9'd5,   8'd120, BLUE,   1'b0};
        vecs[3] = '{9'd159, 8'd119, RED,    1'b1};
        vecs[4] = '{9'd0,   8'd0,   GREEN,  1'b1};
        vecs[5] = '{9'h100, 8'd5,   WHITE,  1'b0};
        vecs[6] = '{9'd20,  8'h80,  YELLOW, 1'b0};
        vecs[7] = '{9'd0,   8'd119, WHITE,  1'b1};
        vecs[8] = '{9'd159, 8'd0,   RED,    1'b1};

        // Reset state
        @(negedge clk);
        check("rst_plot",     32'(plot),        32'd0);
        check("rst_empty",    32'(empty),       32'd1);
        check("rst_in_ready", 32'(pif.in_ready), 32'd1);
        check("rst_drop",     32'(drop_count),  32'd0);
        check("rst_xyc",      32'({x, y, colour}), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single pixel: strobe two cycles after presentation
        out_en = 1'b1;
        send(9'd80, 8'd60, BLUE, 1'b1);
        check("single_e0_plot", 32'(plot), 32'd0);
        @(negedge clk);
        check("single_plot",   32'(plot),   32'd1);
        check("single_x",      32'(x),      32'd80);
        check("single_y",      32'(y),      32'd60);
        check("single_colour", 32'(colour), 32'd1);
        @(negedge clk);
        check("single_plot_off", 32'(plot), 32'd0);
        check("single_x_hold",   32'(x),    32'd80);

        // Clip table
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].vx, vecs[i].vy, vecs[i].vc, vecs[i].keep);
            if (i == 3) check("clip_drop3", 32'(drop_count), 32'd3);
        end
        repeat (4) @(negedge clk);
        check("clip_drop_total", 32'(drop_count), 32'(exp_drops));
        check("clip_sb_empty",   32'(sb.size()),  32'd0);

        // Backpressure: fill with out_en low, ninth pixel must wait
        out_en = 1'b0;
        for (int k = 0; k < 8; k++) send(9'(10 + k), 8'(20 + k), 3'(k), 1'b1);
        check("full_in_ready", 32'(pif.in_ready), 32'd0);
        check("full_empty",    32'(empty),        32'd0);
        pif.in_valid  = 1'b1;
        pif.in_x      = 9'd50;
        pif.in_y      = 8'd50;
        pif.in_colour = YELLOW;
        @(negedge clk);
        check("full_hold_ready", 32'(pif.in_ready), 32'd0);
        check("full_hold_plot",  32'(plot),         32'd0);
        out_en  = 1'b1;
        bp_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rdy = pif.in_ready;
            @(posedge clk);
            if (pif.in_valid && rdy) begin
                record(9'd50, 8'd50, YELLOW, 1'b1);
                bp_done  = 1'b1;
                accept_k = k;
            end
            @(negedge clk);
            if (bp_done) pif.in_valid = 1'b0;
            check("drain_plot", 32'(plot), (k < 9) ? 32'd1 : 32'd0);
        end
        check("ninth_accept_cycle", 32'(accept_k), 32'd1);
        check("drain_sb_empty",     32'(sb.size()), 32'd0);

        // Sustained stream: push and pop every cycle
        for (int k = 0; k < 22; k++) begin
            if (k < 20) begin
                pif.in_valid  = 1'b1;
                pif.in_x      = 9'(k * 7);
                pif.in_y      = 8'(k * 5);
                pif.in_colour = 3'(k);
            end else begin
                pif.in_valid = 1'b0;
            end
            rdy = pif.in_ready;
            @(posedge clk);
            if (pif.in_valid) begin
                if (rdy) record(pif.in_x, pif.in_y, pif.in_colour, 1'b1);
                else check("stream_ready", 32'(rdy), 32'd1);
            end
            @(negedge clk);
            check("stream_plot",  32'(plot),  (k >= 1 && k <= 20) ? 32'd1 : 32'd0);
            check("stream_empty", 32'(empty), (k >= 20) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset in the middle of a drain
        out_en = 1'b0;
        for (int k = 0; k < 4; k++) send(9'(100 + k), 8'(40 + k), GREEN, 1'b1);
        out_en = 1'b1;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_plot",     32'(plot),         32'd0);
        check("mid_rst_empty",    32'(empty),        32'd1);
        check("mid_rst_in_ready", 32'(pif.in_ready), 32'd1);
        check("mid_rst_drop",     32'(drop_count),   32'd0);
        check("mid_rst_xyc",      32'({x, y, colour}), 32'd0);
        sb.delete();
        exp_drops = 0;
        snap = plot_count;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        check("no_stale_plot", 32'(plot_count), 32'(snap));

        // Flush with entries queued; drop counter must survive
        out_en = 1'b0;
        send(9'h1FF, 8'd0, RED, 1'b0);
        send(9'd200, 8'd0, RED, 1'b0);
        for (int k = 0; k < 5; k++) send(9'(60 + k), 8'(30 + k), BLUE, 1'b1);
        check("pre_flush_drop",  32'(drop_count), 32'd2);
        check("pre_flush_empty", 32'(empty),      32'd0);
        sb.delete();
        out_en        = 1'b1;
        sync_clear    = 1'b1;
        pif.in_valid  = 1'b1;
        pif.in_x      = 9'd30;
        pif.in_y      = 8'd30;
        pif.in_colour = WHITE;
        @(negedge clk);
        pif.in_x      = 9'h1F0;
        @(negedge clk);
        sync_clear   = 1'b0;
        pif.in_valid = 1'b0;
        check("flush_empty", 32'(empty),      32'd1);
        check("flush_drop",  32'(drop_count), 32'd2);
        check("flush_plot",  32'(plot),       32'd0);
        snap = plot_count;
        repeat (4) @(negedge clk);
        check("flush_no_plot", 32'(plot_count), 32'(snap));
        send(9'd70, 8'd40, GREEN, 1'b1);
        repeat (3) @(negedge clk);
        check("post_flush_plot",  32'(plot_count), 32'(snap + 1));
        check("post_flush_sb",    32'(sb.size()),  32'd0);
        check("post_flush_drop",  32'(drop_count), 32'(exp_drops));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
